hc194_seq_ctrl: RTL and testbench

//  Sequencer for the HC194 4-bit universal shift register in the XYF top.

---
 rtl/hc194_pkg.sv | 30 +++
 rtl/hc194_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_hc194_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc194_pkg.sv
// HC194 sequencer shared definitions.
// Op codes, HC194 mode pin codes and FSM states.
package hc194_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHR  = 2'b01,
      OP_SHL  = 2'b10,
      OP_ROTR = 2'b11
   } op_e;

   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_SHR  = 2'b01;
   localparam logic [1:0] S_SHL  = 2'b10;
   localparam logic [1:0] S_LOAD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_CAPT  = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   // Mode pins used while shifting: only SHL goes left.
   function automatic logic [1:0] shift_mode(input op_e op);
      return (op == OP_SHL) ? S_SHL : S_SHR;
   endfunction

endpackage

// File: rtl/hc194_seq_ctrl.sv
// Command sequencer for an HC194 universal shift register.
// Runs load + N shifts, captures Q and returns it on a valid/ready port.
module hc194_seq_ctrl #(
   parameter int CNT_W = 3
) (
   input  logic             CP,
   input  logic             MR,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [0:3]       cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [0:3]       rsp_data,
   output logic             busy,
   output logic [1:0]       S,
   output logic [0:3]       D,
   output logic             DSR,
   output logic             DSL,
   input  logic [0:3]       Q
);

   import hc194_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [0:3]       data_q, data_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fill_q, fill_d;
   logic [0:3]       rsp_q, rsp_d;

   // State, latched command, counter and result registers.
   always_ff @(posedge CP or negedge MR) begin
      if (!MR) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         rsp_q   <= rsp_d;
      end
   end

   // Next-state, command latch, shift counter and result capture.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      rsp_d   = rsp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               data_d  = cmd_data;
               len_d   = cmd_count;
               fill_d  = cmd_fill;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d = len_q;
            if (op_q == OP_LOAD || len_q == CNT_ZERO)
               state_d = ST_CAPT;
            else
               state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE)
               state_d = ST_CAPT;
         end
         ST_CAPT: begin
            rsp_d   = Q;
            cnt_d   = CNT_ZERO;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // HC194 pin decode from registered state and latched command only.
   always_comb begin
      S         = S_HOLD;
      D         = '0;
      DSR       = 1'b0;
      DSL       = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: cmd_ready = 1'b1;
         ST_LOAD: begin
            S = S_LOAD;
            D = data_q;
         end
         ST_SHIFT: begin
            S = shift_mode(op_q);
            unique case (1'b1)
               (op_q == OP_SHR):  DSR = fill_q;
               (op_q == OP_ROTR): DSR = Q[3];
               (op_q == OP_SHL):  DSL = fill_q;
               default: ;
            endcase
         end
         ST_CAPT: ;
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign rsp_data = rsp_q;

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Bench for hc194_seq_ctrl driving an HC194 model on shared CP/MR.
// Scoreboard queue of expected responses, monitor on the falling edge.
module tb_hc194_seq_ctrl;

   import hc194_pkg::*;

   localparam int CNT_W = 3;

   logic             CP = 1'b0;
   logic             MR = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [0:3]       cmd_data = 4'b0000;
   logic [CNT_W-1:0] cmd_count = '0;
   logic             cmd_fill = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [0:3]       rsp_data;
   logic             busy;
   logic [1:0]       S;
   logic [0:3]       D;
   logic             DSR;
   logic             DSL;
   logic [0:3]       Q;

   hc194_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .CP(CP), .MR(MR),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cmd_count(cmd_count), .cmd_fill(cmd_fill),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .busy(busy),
      .S(S), .D(D), .DSR(DSR), .DSL(DSL), .Q(Q)
   );

   always #5 CP = ~CP;

   // HC194 behavioural model.
   always @(posedge CP or negedge MR) begin
      if (!MR) Q <= 4'b0000;
      else begin
         case (S)
            2'b01: Q <= {DSR, Q[0:2]};
            2'b10: Q <= {Q[1:3], DSL};
            2'b11: Q <= D;
            default: Q <= Q;
         endcase
      end
   end

   int cyc = 0;
   always @(posedge CP) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      int data;
      int at;
   } exp_t;
   exp_t exp_q[$];

   logic [1:0] cur_op = 2'b00;
   logic [0:3] cur_data = 4'b0000;
   logic       cur_fill = 1'b0;
   bit         rdy_rand = 1'b1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: Q0 is the weight-8 bit, so SHR is v>>1 with fill at 8.
   function automatic int ref_result(input int op, input int d,
                                     input int n, input int f);
      int v = d;
      if (op == 0) return d;
      for (int i = 0; i < n; i++) begin
         if (op == 1)      v = (f * 8) + (v / 2);
         else if (op == 2) v = ((v * 2) % 16) + f;
         else              v = ((v % 2) * 8) + (v / 2);
      end
      return v;
   endfunction

   // Random response backpressure, driven away from the sampling edge.
   initial begin
      forever begin
         @(posedge CP);
         #2;
         if (rdy_rand) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pin legality, response latency, hold and data.
   logic       prev_v = 1'b0;
   logic [0:3] held = 4'b0000;
   always @(negedge CP) begin
      if (!MR) prev_v = 1'b0;
      else begin
         chk("pin_D", int'(D), (S == S_LOAD) ? int'(cur_data) : 0);
         chk("pin_DSL", int'(DSL), (S == S_SHL) ? int'(cur_fill) : 0);
         chk("pin_DSR", int'(DSR), (S != S_SHR) ? 0 :
             (cur_op == OP_ROTR) ? int'(Q[3]) : int'(cur_fill));
         if (S == S_SHR || S == S_SHL)
            chk("pin_S_dir", int'(S),
                (cur_op == OP_SHL) ? int'(S_SHL) : int'(S_SHR));
         if (rsp_valid) begin
            if (!prev_v) begin
               if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
               else chk("rsp_latency", cyc, exp_q[0].at);
               held = rsp_data;
            end else begin
               chk("rsp_hold", int'(rsp_data), int'(held));
            end
            if (rsp_ready && exp_q.size() > 0) begin
               chk("rsp_data", int'(rsp_data), exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
         prev_v = rsp_valid && !rsp_ready;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [0:3] d,
                        input int n, input logic f);
      int w = 0;
      int eff;
      exp_t e;
      @(negedge CP);
      while (!cmd_ready && w < 200) begin
         @(negedge CP);
         w++;
      end
      if (!cmd_ready) begin
         chk("issue_timeout", 0, 1);
         return;
      end
      eff = (op == OP_LOAD) ? 0 : n;
      e.data = ref_result(int'(op), int'(d), n, int'(f));
      e.at = cyc + 1 + eff + 2;
      exp_q.push_back(e);
      cur_op = op;
      cur_data = d;
      cur_fill = f;
      cmd_op = op;
      cmd_data = d;
      cmd_count = CNT_W'(n);
      cmd_fill = f;
      cmd_valid = 1'b1;
      @(negedge CP);
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom_range(0, 3));
      cmd_data = 4'($urandom_range(0, 15));
      cmd_count = CNT_W'($urandom_range(0, 7));
      cmd_fill = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int w = 0;
      @(negedge CP);
      while ((busy || rsp_valid) && w < 300) begin
         @(negedge CP);
         w++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // Reset values while MR is low.
      repeat (2) @(negedge CP);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_S", int'(S), 0);
      chk("rst_D", int'(D), 0);
      chk("rst_DSR_DSL", int'({DSR, DSL}), 0);
      @(posedge CP);
      #2 MR = 1'b1;
      @(negedge CP);
      chk("rst_cmd_ready", int'(cmd_ready), 1);

      // 1: LOAD count=0, mode sequence load then hold.
      issue(OP_LOAD, 4'b1011, 0, 1'b0);
      chk("t1_S_load", int'(S), int'(S_LOAD));
      @(negedge CP);
      chk("t1_S_hold", int'(S), int'(S_HOLD));
      wait_idle();

      // 2: SHR count=2 fill=0, watch Q step by step.
      issue(OP_SHR, 4'b1011, 2, 1'b0);
      chk("t2_S_load", int'(S), int'(S_LOAD));
      @(negedge CP);
      chk("t2_Q_load", int'(Q), int'(4'b1011));
      chk("t2_S_shr", int'(S), int'(S_SHR));
      @(negedge CP);
      chk("t2_Q_sh1", int'(Q), int'(4'b0101));
      @(negedge CP);
      chk("t2_Q_sh2", int'(Q), int'(4'b0010));
      chk("t2_S_capt", int'(S), int'(S_HOLD));
      wait_idle();

      // 3: SHL count=1 fill=1, DSL only while shifting.
      issue(OP_SHL, 4'b1011, 1, 1'b1);
      chk("t3_DSL_load", int'(DSL), 0);
      @(negedge CP);
      chk("t3_DSL_shift", int'(DSL), 1);
      @(negedge CP);
      chk("t3_DSL_capt", int'(DSL), 0);
      wait_idle();

      // 4: ROTR max count, fill must not leak into DSR.
      issue(OP_ROTR, 4'b1000, 7, 1'b1);
      wait_idle();

      // Shift op with count=0 goes straight to capture.
      issue(OP_SHR, 4'b0110, 0, 1'b1);
      wait_idle();

      // 5: backpressure, response holds and cmd pulse is ignored.
      rdy_rand = 1'b0;
      @(posedge CP);
      #2 rsp_ready = 1'b0;
      issue(OP_LOAD, 4'b0101, 0, 1'b0);
      w = 0;
      while (!rsp_valid && w < 50) begin
         @(negedge CP);
         w++;
      end
      chk("t5_rsp_seen", int'(rsp_valid), 1);
      for (int i = 0; i < 3; i++) begin
         chk("t5_cmd_ready", int'(cmd_ready), 0);
         chk("t5_rsp_valid", int'(rsp_valid), 1);
         chk("t5_rsp_data", int'(rsp_data), int'(4'b0101));
         cmd_op = OP_SHL;
         cmd_data = 4'b1111;
         cmd_count = CNT_W'(3);
         cmd_valid = (i == 1);
         @(negedge CP);
      end
      cmd_valid = 1'b0;
      @(posedge CP);
      #2 rsp_ready = 1'b1;
      rdy_rand = 1'b1;
      wait_idle();

      // 6: reset in the 2nd SHIFT cycle drops the command.
      issue(OP_SHR, 4'b1011, 5, 1'b1);
      @(negedge CP);
      @(negedge CP);
      chk("t6_in_shift", int'(S), int'(S_SHR));
      #1 MR = 1'b0;
      #1;
      chk("t6_S", int'(S), 0);
      chk("t6_busy", int'(busy), 0);
      chk("t6_rsp_valid", int'(rsp_valid), 0);
      exp_q.delete();
      @(negedge CP);
      @(posedge CP);
      #2 MR = 1'b1;
      @(negedge CP);
      chk("t6_cmd_ready", int'(cmd_ready), 1);
      issue(OP_LOAD, 4'b0110, 0, 1'b0);
      wait_idle();

      // Random commands against the reference model.
      for (int k = 0; k < 40; k++) begin
         issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
